// File: rtl/display_bcd_scan.sv
// display_bcd_scan: signed product -> sequential double-dabble BCD -> 8-slot multiplexed display (digito code, active-low anodos)
module display_bcd_scan #(
  parameter int N = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] producto,
  output logic         busy,
  output logic         done,
  output logic [3:0]   digito,
  output logic [7:0]   anodos
);
  localparam int D0 = (N * 301) / 1000 + 1;
  localparam int D = D0 < 5 ? 5 : D0;
  localparam int CW = $clog2(N);
  localparam int PW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;
  state_t state, state_n;
  logic [N-1:0] mag;
  logic [4*D-1:0] bcd, adj, disp, disp_n;
  logic [CW-1:0] cnt;
  logic sign, disp_sign, sign_n, tick;
  logic [PW-1:0] pre;
  logic [2:0] idx, idx_n;
  logic [31:0] ext;
  logic [7:0] anodos_n;
  logic [3:0] digito_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE  ? (start ? CONV : IDLE) :
              state == CONV  ? (cnt == CW'(N - 1) ? LATCH : CONV) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == LATCH;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < D; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // slot outputs are computed from the values the display/scan registers take
  // on this same edge, so new digits appear the cycle right after done
  always_comb begin
    tick = pre == PW'(REFRESH_DIV - 1);
    idx_n = tick ? idx + 3'd1 : idx;
    disp_n = done ? bcd : disp;
    sign_n = done ? sign : disp_sign;
    ext = 32'(disp_n[19:0]);
    anodos_n = idx_n < 3'd5 ? ~(8'd1 << idx_n) : (idx_n == 3'd5 && sign_n) ? 8'hDF : 8'hFF;
    digito_n = idx_n < 3'd5 ? ext[{idx_n, 2'b00} +: 4] : (idx_n == 3'd5 && sign_n) ? 4'hA : 4'h0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
      sign <= 1'b0;
      disp <= '0;
      disp_sign <= 1'b0;
      pre <= '0;
      idx <= '0;
      anodos <= 8'hFE;
      digito <= 4'd0;
    end else begin
      if (state == IDLE && start) begin
        sign <= producto[N-1];
        mag <= producto[N-1] ? -producto : producto;
        bcd <= '0;
        cnt <= '0;
      end
      if (state == CONV) begin
        {bcd, mag} <= {adj[4*D-2:0], mag, 1'b0};
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        disp <= bcd;
        disp_sign <= sign;
      end
      pre <= tick ? '0 : pre + 1'b1;
      idx <= idx_n;
      anodos <= anodos_n;
      digito <= digito_n;
    end
endmodule

// File: tb/tb_display_bcd_scan.sv
// tb_display_bcd_scan: table-driven and sequence checks of conversion, latency, busy handling, reset and scan
module tb_display_bcd_scan;
  logic clk = 0, rst = 0, start = 0;
  logic [15:0] producto = '0;
  logic busy, done;
  logic [3:0] digito;
  logic [7:0] anodos;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  display_bcd_scan #(.N(16), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .producto(producto),
    .busy(busy), .done(done), .digito(digito), .anodos(anodos)
  );
  typedef struct {
    logic [15:0] p;
    logic [19:0] bcd;
    logic neg;
  } vec_t;
  vec_t v[7];
  logic [7:0] pat[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic convert(input logic [15:0] p, output int lat);
    producto = p;
    start = 1;
    tick;
    start = 0;
    lat = 0;
    while (!done && lat < 40) begin
      tick;
      lat++;
    end
  endtask
  task automatic capture(output logic [19:0] dig, output logic neg, output logic [3:0] negd,
                         output logic blank_ok, output logic saw_done);
    dig = '0;
    neg = 0;
    negd = 0;
    blank_ok = 1;
    saw_done = 0;
    repeat (32) begin
      if (done) saw_done = 1;
      case (anodos)
        8'hFE: dig[3:0] = digito;
        8'hFD: dig[7:4] = digito;
        8'hFB: dig[11:8] = digito;
        8'hF7: dig[15:12] = digito;
        8'hEF: dig[19:16] = digito;
        8'hDF: begin neg = 1; negd = digito; end
        8'hFF: if (digito !== 4'd0) blank_ok = 0;
        default: blank_ok = 0;
      endcase
      tick;
    end
  endtask
  initial begin
    int lat;
    logic [19:0] dig;
    logic neg, blank_ok, saw_done, found;
    logic [3:0] negd;
    logic [7:0] prev;
    v[0] = '{16'd1234, 20'h01234, 1'b0};
    v[1] = '{16'h8000, 20'h32768, 1'b1};
    v[2] = '{16'hFFFF, 20'h00001, 1'b1};
    v[3] = '{16'h0000, 20'h00000, 1'b0};
    v[4] = '{16'd42,   20'h00042, 1'b0};
    v[5] = '{16'h7FFF, 20'h32767, 1'b0};
    v[6] = '{16'hFF9C, 20'h00100, 1'b1};
    pat = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
    #1 rst = 1;
    #10;
    chk("reset anodos", anodos, 8'hFE);
    chk("reset digito", digito, 4'd0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    tick;
    rst = 0;
    tick;
    for (int i = 0; i < 7; i++) begin
      convert(v[i].p, lat);
      chk($sformatf("vec%0d latency", i), lat, 16);
      tick;
      capture(dig, neg, negd, blank_ok, saw_done);
      chk($sformatf("vec%0d digits", i), dig, v[i].bcd);
      chk($sformatf("vec%0d sign", i), neg, v[i].neg);
      chk($sformatf("vec%0d sign code", i), negd, v[i].neg ? 4'hA : 4'h0);
      chk($sformatf("vec%0d blanks", i), blank_ok, 1'b1);
      chk($sformatf("vec%0d extra done", i), saw_done, 1'b0);
    end
    producto = 16'd555;
    start = 1;
    tick;
    start = 0;
    lat = 0;
    repeat (4) begin
      tick;
      lat++;
    end
    chk("busy during conv", busy, 1'b1);
    producto = 16'd999;
    start = 1;
    tick;
    lat++;
    start = 0;
    while (!done && lat < 40) begin
      tick;
      lat++;
    end
    chk("busy-start latency", lat, 16);
    producto = 16'd777;
    start = 1;
    tick;
    start = 0;
    chk("start in latch ignored", busy, 1'b0);
    chk("done single pulse", done, 1'b0);
    capture(dig, neg, negd, blank_ok, saw_done);
    chk("busy-start digits", dig, 20'h00555);
    chk("busy-start no 2nd done", saw_done, 1'b0);
    convert(16'd777, lat);
    chk("post-done latency", lat, 16);
    tick;
    capture(dig, neg, negd, blank_ok, saw_done);
    chk("post-done digits", dig, 20'h00777);
    producto = 16'h1111;
    start = 1;
    tick;
    start = 0;
    repeat (5) tick;
    #2 rst = 1;
    #1;
    chk("async rst anodos", anodos, 8'hFE);
    chk("async rst digito", digito, 4'd0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst done", done, 1'b0);
    tick;
    rst = 0;
    tick;
    capture(dig, neg, negd, blank_ok, saw_done);
    chk("abort digits", dig, 20'h00000);
    chk("abort sign", neg, 1'b0);
    chk("abort no done", saw_done, 1'b0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      prev = anodos;
      tick;
      if (anodos == 8'hFE && prev != 8'hFE) found = 1;
    end
    chk("scan sync", found, 1'b1);
    for (int k = 0; k < 36; k++) begin
      chk($sformatf("scan k%0d", k), anodos, pat[(k / 4) % 8]);
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
